// File: rtl/uart_frame_tx_if.sv
// -----------------------------------------------------------------------------
// uart_frame_tx_if
//   Groups the payload stream, the uart_tx byte handoff and the frame status
//   of uart_frame_tx. Signal names are seen from the framer's side, so the
//   framer connects through the slave modport and the producer (or a bench)
//   connects through the master modport.
//
//   i_valid, i_data[7:0], i_last  payload byte offered, i_last ends the frame
//   o_ready                       framer accepts the payload byte this cycle
//   o_tx_enable, o_tx_data[7:0]   one-cycle start pulse and byte for uart_tx
//   i_tx_busy                     uart_tx busy flag
//   o_busy                        a frame is being transmitted
//   o_overflow                    one-cycle pulse when a frame is closed at MaxLen
// -----------------------------------------------------------------------------
interface uart_frame_tx_if;
   logic       i_valid;
   logic [7:0] i_data;
   logic       i_last;
   logic       o_ready;
   logic       o_tx_enable;
   logic [7:0] o_tx_data;
   logic       i_tx_busy;
   logic       o_busy;
   logic       o_overflow;

   modport slave (
      input  i_valid, i_data, i_last, i_tx_busy,
      output o_ready, o_tx_enable, o_tx_data, o_busy, o_overflow
   );

   modport master (
      output i_valid, i_data, i_last, i_tx_busy,
      input  o_ready, o_tx_enable, o_tx_data, o_busy, o_overflow
   );
endinterface

// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//   Collects a variable-length payload (1..MaxLen bytes) and sends it to a
//   byte-wide uart_tx as the frame  A5, LEN, payload..., CHK  where CHK is the
//   XOR of LEN and every payload byte. The payload is buffered because LEN has
//   to go out before it. Each byte is handed over with a one-cycle enable
//   pulse, then the framer waits for uart_tx busy to rise and to fall again.
//
//   Parameter MaxLen  maximum payload bytes per frame (1..255)
//   i_clk             clock
//   i_rst             synchronous active-high reset; aborts any frame
//   bus               uart_frame_tx_if.slave (payload stream, uart_tx port,
//                     o_busy and o_overflow status)
// -----------------------------------------------------------------------------
module uart_frame_tx #(
   parameter int MaxLen = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   uart_frame_tx_if.slave bus
);

   localparam logic [7:0] SofByte = 8'hA5;
   localparam int CntW = $clog2(MaxLen + 1);
   localparam int IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxLen);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_SOF,
      ST_LEN,
      ST_PAY,
      ST_CHK
   } state_e;

   // Handshake substep used by every byte-sending state.
   typedef enum logic [1:0] {
      SUB_PULSE,
      SUB_WAIT_HI,
      SUB_WAIT_LO
   } sub_e;

   state_e          state_q;
   sub_e            sub_q;
   logic [CntW-1:0] cnt_q;      // payload bytes collected, becomes LEN
   logic [7:0]      chk_q;      // running payload XOR, final CHK after close
   logic [IdxW-1:0] rd_idx_q;   // payload index being sent in ST_PAY
   logic [7:0]      tx_data_q;
   logic            ovf_q;
   logic [7:0]      buf_q [MaxLen];

   logic            collecting;
   logic            sending;
   logic            xfer;
   logic [CntW-1:0] cnt_d;
   logic [IdxW-1:0] wr_idx_d;
   logic [7:0]      chk_d;
   logic            close_d;
   logic            rd_last;

   assign collecting = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
   assign sending    = !collecting;
   assign xfer       = bus.i_valid && bus.o_ready;

   // Count, write index and running checksum as they become after the byte
   // on the bus is taken; a byte taken in IDLE starts a fresh frame.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      cnt_d    = CntW'(1);
      wr_idx_d = '0;
      chk_d    = bus.i_data;
      if (state_q == ST_COLLECT) begin
         cnt_d    = cnt_q + CntW'(1);
         wr_idx_d = IdxW'(cnt_q);
         chk_d    = chk_q ^ bus.i_data;
      end
      close_d = bus.i_last || (cnt_d == MaxCnt);
   end

   assign rd_last = (CntW'(rd_idx_q) + CntW'(1)) == cnt_q;

   // NOTE: the payload store has no reset; every entry read in ST_PAY was
   // written earlier in the same frame.
   always_ff @(posedge i_clk) begin
      if (xfer) begin
         buf_q[wr_idx_d] <= bus.i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: all state is updated with non-blocking assignments so every
      // register samples the pre-edge values, whatever the statement order.
      ovf_q <= 1'b0;
      if (i_rst) begin
         state_q   <= ST_IDLE;
         sub_q     <= SUB_PULSE;
         cnt_q     <= '0;
         chk_q     <= '0;
         rd_idx_q  <= '0;
         tx_data_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_COLLECT: begin
               if (xfer) begin
                  cnt_q <= cnt_d;
                  if (close_d) begin
                     // LEN is folded in here so CHK is ready before SOF goes out.
                     chk_q     <= chk_d ^ 8'(cnt_d);
                     state_q   <= ST_SOF;
                     sub_q     <= SUB_PULSE;
                     tx_data_q <= SofByte;
                     ovf_q     <= !bus.i_last;
                  end else begin
                     chk_q   <= chk_d;
                     state_q <= ST_COLLECT;
                  end
               end
            end
            ST_SOF, ST_LEN, ST_PAY, ST_CHK: begin
               case (sub_q)
                  SUB_PULSE: begin
                     if (!bus.i_tx_busy) begin
                        sub_q <= SUB_WAIT_HI;
                     end
                  end
                  SUB_WAIT_HI: begin
                     if (bus.i_tx_busy) begin
                        sub_q <= SUB_WAIT_LO;
                     end
                  end
                  default: begin
                     // uart_tx has finished this byte: load the next one.
                     if (!bus.i_tx_busy) begin
                        sub_q <= SUB_PULSE;
                        case (state_q)
                           ST_SOF: begin
                              state_q   <= ST_LEN;
                              tx_data_q <= 8'(cnt_q);
                           end
                           ST_LEN: begin
                              state_q   <= ST_PAY;
                              rd_idx_q  <= '0;
                              tx_data_q <= buf_q[IdxW'(0)];
                           end
                           ST_PAY: begin
                              if (rd_last) begin
                                 state_q   <= ST_CHK;
                                 tx_data_q <= chk_q;
                              end else begin
                                 rd_idx_q  <= rd_idx_q + IdxW'(1);
                                 tx_data_q <= buf_q[rd_idx_q + IdxW'(1)];
                              end
                           end
                           default: begin
                              state_q <= ST_IDLE;
                           end
                        endcase
                     end
                  end
               endcase
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode registered state. The enable also looks at the live busy
   // flag so the pulse lands on the first busy-low cycle and never overlaps
   // busy; the reset term keeps every output idle while reset is held.
   assign bus.o_ready     = collecting && !i_rst;
   assign bus.o_busy      = sending && !i_rst;
   assign bus.o_tx_enable = sending && (sub_q == SUB_PULSE) && !bus.i_tx_busy && !i_rst;
   assign bus.o_tx_data   = i_rst ? 8'h00 : tx_data_q;
   assign bus.o_overflow  = ovf_q && !i_rst;

endmodule

// File: tb/tb_uart_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_tx
//   Self-checking bench for uart_frame_tx. A small uart_tx model records every
//   byte handed over by o_tx_enable and raises busy for busy_len cycles. Frames
//   are compared byte by byte against either a constant table or a reference
//   model that builds A5, LEN, payload, XOR directly from the payload list.
// -----------------------------------------------------------------------------
module tb_uart_frame_tx;

   localparam int MaxLen = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_frame_tx_if bus();

   uart_frame_tx #(.MaxLen(MaxLen)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- uart_tx model and monitors ----------------
   int         busy_cnt        = 0;
   int         busy_len        = 10;
   logic       force_busy      = 1'b0;
   logic [7:0] sent_q[$];
   int         en_pulses       = 0;
   int         en_busy_viol    = 0;
   int         ovf_pulses      = 0;
   int         ready_busy_viol = 0;

   assign bus.i_tx_busy = (busy_cnt != 0) || force_busy;

   always @(posedge clk) begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (bus.o_tx_enable) begin
         sent_q.push_back(bus.o_tx_data);
         en_pulses <= en_pulses + 1;
         if (bus.i_tx_busy) en_busy_viol <= en_busy_viol + 1;
         busy_cnt <= busy_len;
      end
   end

   always @(negedge clk) begin
      if (bus.o_overflow) ovf_pulses <= ovf_pulses + 1;
      if (bus.o_ready && bus.o_busy) ready_busy_viol <= ready_busy_viol + 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] stim_q[$];
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Reference frame built straight from the frame format rules.
   function automatic void model_frame();
      int n;
      logic [7:0] x;
      n = (stim_q.size() > MaxLen) ? MaxLen : stim_q.size();
      x = 8'(n);
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(stim_q[i]);
         x = x ^ stim_q[i];
      end
      exp_q.push_back(x);
   endfunction

   // Called at posedge+1; returns at posedge+1 right after the transfer edge.
   task automatic offer_byte(input logic [7:0] d, input logic l, input string tag);
      int guard;
      guard = 0;
      bus.i_valid = 1'b1;
      bus.i_data  = d;
      bus.i_last  = l;
      @(negedge clk);
      while (!bus.o_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " accept"}, 32'(bus.o_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
   endtask

   task automatic run_stim(input bit gaps, input string tag);
      for (int i = 0; i < stim_q.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               bus.i_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         offer_byte(stim_q[i], (i == stim_q.size() - 1), tag);
      end
   endtask

   task automatic wait_frame(input int start, input string tag);
      int guard;
      guard = 0;
      @(negedge clk);
      while ((sent_q.size() < start + exp_q.size() || bus.o_busy) && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " done"}, 32'(guard < 5000), 32'd1);
      check({tag, " count"}, 32'(sent_q.size() - start), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (start + k < sent_q.size())
            check($sformatf("%s byte%0d", tag, k), 32'(sent_q[start + k]), 32'(exp_q[k]));
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int              n;
      logic [0:3][7:0] pay;
      int              busy;
      int              exp_n;
      logic [0:6][7:0] exp;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int start;
      int en0;
      int ovf0;
      int viol0;
      int guard;

      vecs[0] = '{n: 3, pay: {8'h11, 8'h22, 8'h33, 8'h00}, busy: 10, exp_n: 6,
                  exp: {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00}};
      vecs[1] = '{n: 1, pay: {8'h5A, 8'h00, 8'h00, 8'h00}, busy: 10, exp_n: 4,
                  exp: {8'hA5, 8'h01, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00}};
      vecs[2] = '{n: 2, pay: {8'hFF, 8'h01, 8'h00, 8'h00}, busy: 2, exp_n: 5,
                  exp: {8'hA5, 8'h02, 8'hFF, 8'h01, 8'hFC, 8'h00, 8'h00}};
      vecs[3] = '{n: 4, pay: {8'h80, 8'h40, 8'h20, 8'h10}, busy: 1, exp_n: 7,
                  exp: {8'hA5, 8'h04, 8'h80, 8'h40, 8'h20, 8'h10, 8'hF4}};

      bus.i_valid = 1'b0;
      bus.i_data  = 8'h00;
      bus.i_last  = 1'b0;

      // Reset state and release.
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset outputs", {bus.o_ready, bus.o_busy, bus.o_tx_enable, bus.o_overflow, bus.o_tx_data},
            32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("release ready", 32'(bus.o_ready), 32'd1);
      check("release enable", 32'(bus.o_tx_enable), 32'd0);
      @(posedge clk);
      #1;

      // Table-driven frames.
      for (int v = 0; v < 4; v++) begin
         busy_len = vecs[v].busy;
         stim_q.delete();
         exp_q.delete();
         for (int i = 0; i < vecs[v].n; i++) stim_q.push_back(vecs[v].pay[i]);
         for (int i = 0; i < vecs[v].exp_n; i++) exp_q.push_back(vecs[v].exp[i]);
         start = sent_q.size();
         en0   = en_pulses;
         ovf0  = ovf_pulses;
         run_stim(1'b0, $sformatf("vec%0d", v));
         wait_frame(start, $sformatf("vec%0d", v));
         check($sformatf("vec%0d enables", v), 32'(en_pulses - en0), 32'(vecs[v].exp_n));
         check($sformatf("vec%0d no overflow", v), 32'(ovf_pulses - ovf0), 32'd0);
      end

      // Overflow: 17 bytes, i_last never set; the frame closes at MaxLen.
      busy_len = 10;
      stim_q.delete();
      for (int i = 0; i <= MaxLen; i++) stim_q.push_back(8'(i));
      model_frame();
      start = sent_q.size();
      ovf0  = ovf_pulses;
      for (int i = 0; i < MaxLen; i++) offer_byte(stim_q[i], 1'b0, "ovf");
      @(negedge clk);
      check("ovf pulse", 32'(bus.o_overflow), 32'd1);
      check("ovf ready low", 32'(bus.o_ready), 32'd0);
      @(posedge clk);
      #1;
      offer_byte(stim_q[MaxLen], 1'b0, "ovf extra");
      check("ovf extra after frame", 32'(sent_q.size() - start), 32'(exp_q.size()));
      wait_frame(start, "ovf");
      check("ovf pulses", 32'(ovf_pulses - ovf0), 32'd1);

      // COLLECT with i_valid low holds every output, then reset drops the frame.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("collect hold%0d", c),
               {bus.o_ready, bus.o_busy, bus.o_tx_enable, bus.o_overflow}, 32'b1000);
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      start = sent_q.size();
      repeat (30) @(posedge clk);
      #1;
      check("abort no bytes", 32'(sent_q.size() - start), 32'd0);

      // Busy already high when SOF is ready: no enable until it drops.
      busy_len   = 3;
      force_busy = 1'b1;
      stim_q.delete();
      stim_q.push_back(8'h3C);
      model_frame();
      start = sent_q.size();
      run_stim(1'b0, "busyhold");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("busyhold no enable%0d", c), 32'(bus.o_tx_enable), 32'd0);
         @(posedge clk);
         #1;
      end
      force_busy = 1'b0;
      @(negedge clk);
      check("busyhold sof enable", 32'(bus.o_tx_enable), 32'd1);
      check("busyhold sof data", 32'(bus.o_tx_data), 32'hA5);
      @(posedge clk);
      #1;
      wait_frame(start, "busyhold");

      // Reset while the second of four payload bytes is in flight.
      stim_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
      start  = sent_q.size();
      run_stim(1'b0, "payrst");
      guard = 0;
      @(negedge clk);
      while (sent_q.size() < start + 4 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      check("payrst reached pay", 32'(sent_q.size() - start), 32'd4);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("payrst idle", {bus.o_busy, bus.o_tx_enable, bus.o_ready}, 32'b001);
      @(posedge clk);
      #1;
      stim_q.delete();
      stim_q.push_back(8'h77);
      model_frame();
      start = sent_q.size();
      run_stim(1'b0, "after rst");
      wait_frame(start, "after rst");

      // Five bytes with i_valid toggling at random.
      busy_len = 10;
      viol0    = ready_busy_viol;
      stim_q.delete();
      for (int i = 0; i < 5; i++) stim_q.push_back(8'($urandom));
      model_frame();
      start = sent_q.size();
      run_stim(1'b1, "gappy");
      wait_frame(start, "gappy");
      check("gappy ready during tx", 32'(ready_busy_viol - viol0), 32'd0);

      // Random frames against the reference model.
      for (int f = 0; f < 20; f++) begin
         busy_len = $urandom_range(1, 4);
         stim_q.delete();
         repeat ($urandom_range(1, MaxLen)) stim_q.push_back(8'($urandom));
         model_frame();
         start = sent_q.size();
         ovf0  = ovf_pulses;
         run_stim(1'b1, $sformatf("rnd%0d", f));
         wait_frame(start, $sformatf("rnd%0d", f));
         check($sformatf("rnd%0d no overflow", f), 32'(ovf_pulses - ovf0), 32'd0);
      end

      check("enable while busy", 32'(en_busy_viol), 32'd0);
      check("ready while busy", 32'(ready_busy_viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
